// File: rtl/pitch_frontend_mc.sv
// Multi-channel pitch front end: biases/saturates samples, frames one channel at a
// time into a shared pitch detector and emits its (optionally median-smoothed) result.

module pitch_frontend_mc_hist #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             upd_i,
  input  logic [WIDTH-1:0] new_i,
  output logic [WIDTH-1:0] h0_o,
  output logic [WIDTH-1:0] h1_o,
  output logic [1:0]       fill_o
);
  logic [WIDTH-1:0] h0_q, h1_q;
  logic [1:0]       fill_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      h0_q   <= '0;
      h1_q   <= '0;
      fill_q <= '0;
    end else if (upd_i) begin
      h1_q <= h0_q;
      h0_q <= new_i;
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
    end
  end

  assign h0_o   = h0_q;
  assign h1_o   = h1_q;
  assign fill_o = fill_q;
endmodule

module pitch_frontend_mc #(
  parameter int SIGNAL_WIDTH = 8,
  parameter int WIDTH        = 32,
  parameter int WINDOW_SIZE  = 500,
  parameter int NUM_CH       = 4,
  parameter int TIMEOUT      = 4096,
  parameter int SMOOTH       = 1,
  localparam int CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  enable_in,
  input  logic [SIGNAL_WIDTH:0] audio_in,
  input  logic [CHW-1:0]        audio_in_ch,
  input  logic                  audio_in_valid,
  output logic [SIGNAL_WIDTH:0] det_sig,
  output logic                  det_sig_valid,
  output logic                  det_start,
  input  logic [WIDTH-1:0]      det_f_in,
  input  logic                  det_f_valid,
  output logic [WIDTH-1:0]      f_out,
  output logic [CHW-1:0]        f_out_ch,
  output logic                  f_out_valid,
  output logic                  f_timeout,
  output logic                  busy
);
  localparam logic [1:0] S_IDLE = 2'd0, S_STREAM = 2'd1, S_WAIT = 2'd2, S_EMIT = 2'd3;
  localparam int CW = $clog2(WINDOW_SIZE + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BW = SIGNAL_WIDTH + 3;
  localparam logic signed [BW-1:0] BIAS = BW'((2**SIGNAL_WIDTH) - 1);
  localparam logic signed [BW-1:0] SMAX = BW'((2**(SIGNAL_WIDTH+1)) - 1);

  logic [1:0]            state_q, state_d;
  logic [CHW-1:0]        ch_q, ch_d, fch_q, fch_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [SIGNAL_WIDTH:0] sig_q, sig_d;
  logic                  sigv_q, sigv_d, start_q, start_d;
  logic [WIDTH-1:0]      f_q, f_d;
  logic                  fv_q, fv_d, fto_q, fto_d;

  // Two guard bits keep the biased sum signed and overflow-free before clamping
  logic signed [BW-1:0]  sum;
  logic [SIGNAL_WIDTH:0] sat;
  assign sum = $signed({{2{audio_in[SIGNAL_WIDTH]}}, audio_in}) + BIAS;

  always_comb begin
    sat = sum[SIGNAL_WIDTH:0];
    if (sum[BW-1])       sat = '0;
    else if (sum > SMAX) sat = SMAX[SIGNAL_WIDTH:0];
  end

  logic accept, res_acc;
  assign accept  = (state_q == S_STREAM) && audio_in_valid && (audio_in_ch == ch_q);
  assign res_acc = (state_q == S_WAIT) && det_f_valid;

  logic [NUM_CH-1:0][WIDTH-1:0] h0, h1;
  logic [NUM_CH-1:0][1:0]       fill;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pitch_frontend_mc_hist #(.WIDTH(WIDTH)) u_hist (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .upd_i    (res_acc && (ch_q == CHW'(g))),
      .new_i    (det_f_in),
      .h0_o     (h0[g]),
      .h1_o     (h1[g]),
      .fill_o   (fill[g])
    );
  end

  function automatic logic [WIDTH-1:0] med3(input logic signed [WIDTH-1:0] a, b, c);
    logic signed [WIDTH-1:0] lo, hi, m;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    m  = (hi < c) ? hi : c;
    return (lo > m) ? lo : m;
  endfunction

  logic [WIDTH-1:0] f_new;
  assign f_new = ((SMOOTH != 0) && (fill[ch_q] == 2'd2)) ? med3(det_f_in, h0[ch_q], h1[ch_q])
                                                         : det_f_in;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    sig_d   = sig_q;
    sigv_d  = 1'b0;
    start_d = 1'b0;
    f_d     = f_q;
    fch_d   = fch_q;
    fv_d    = 1'b0;
    fto_d   = 1'b0;
    case (state_q)
      S_IDLE: if (enable_in) begin
        state_d = S_STREAM;
        cnt_d   = '0;
      end
      S_STREAM: if (accept) begin
        sig_d  = sat;
        sigv_d = 1'b1;
        if (cnt_q == CW'(WINDOW_SIZE - 1)) begin
          start_d = 1'b1;
          cnt_d   = '0;
          tmr_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // A result arriving on the expiry cycle takes priority over the timeout
      S_WAIT: if (det_f_valid) begin
        f_d     = f_new;
        fch_d   = ch_q;
        fv_d    = 1'b1;
        state_d = S_EMIT;
      end else if (tmr_q == TW'(TIMEOUT - 1)) begin
        f_d     = '0;
        fch_d   = ch_q;
        fv_d    = 1'b1;
        fto_d   = 1'b1;
        state_d = S_EMIT;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
      default: begin
        ch_d    = (ch_q == CHW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
        cnt_d   = '0;
        state_d = enable_in ? S_STREAM : S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      sig_q   <= '0;
      sigv_q  <= 1'b0;
      start_q <= 1'b0;
      f_q     <= '0;
      fch_q   <= '0;
      fv_q    <= 1'b0;
      fto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      sig_q   <= sig_d;
      sigv_q  <= sigv_d;
      start_q <= start_d;
      f_q     <= f_d;
      fch_q   <= fch_d;
      fv_q    <= fv_d;
      fto_q   <= fto_d;
    end
  end

  assign det_sig       = sig_q;
  assign det_sig_valid = sigv_q;
  assign det_start     = start_q;
  assign f_out         = f_q;
  assign f_out_ch      = fch_q;
  assign f_out_valid   = fv_q;
  assign f_timeout     = fto_q;
  assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_pitch_frontend_mc.sv
// Scoreboard bench for pitch_frontend_mc: smoothed and bypass instances share stimulus.
module tb_pitch_frontend_mc;
  localparam int SW = 8, W = 32, WS = 4, NCH = 2, TO = 16;

  logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [SW:0]   audio = '0;
  logic [0:0]    audio_ch = '0;
  logic          audio_v = 1'b0;
  logic [W-1:0]  det_f = '0;
  logic          det_fv = 1'b0;

  logic [SW:0]   det_sig, det_sig_n;
  logic          det_sig_v, det_sig_v_n, det_start, det_start_n;
  logic [W-1:0]  f_out, f_out_n;
  logic [0:0]    f_ch, f_ch_n;
  logic          f_v, f_v_n, f_to, f_to_n, busy, busy_n;

  always #5 clk = ~clk;

  pitch_frontend_mc #(.SIGNAL_WIDTH(SW), .WIDTH(W), .WINDOW_SIZE(WS), .NUM_CH(NCH),
                      .TIMEOUT(TO), .SMOOTH(1)) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(enable), .audio_in(audio),
    .audio_in_ch(audio_ch), .audio_in_valid(audio_v), .det_sig(det_sig),
    .det_sig_valid(det_sig_v), .det_start(det_start), .det_f_in(det_f),
    .det_f_valid(det_fv), .f_out(f_out), .f_out_ch(f_ch), .f_out_valid(f_v),
    .f_timeout(f_to), .busy(busy));

  pitch_frontend_mc #(.SIGNAL_WIDTH(SW), .WIDTH(W), .WINDOW_SIZE(WS), .NUM_CH(NCH),
                      .TIMEOUT(TO), .SMOOTH(0)) u_dut_ns (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(enable), .audio_in(audio),
    .audio_in_ch(audio_ch), .audio_in_valid(audio_v), .det_sig(det_sig_n),
    .det_sig_valid(det_sig_v_n), .det_start(det_start_n), .det_f_in(det_f),
    .det_f_valid(det_fv), .f_out(f_out_n), .f_out_ch(f_ch_n), .f_out_valid(f_v_n),
    .f_timeout(f_to_n), .busy(busy_n));

  typedef struct { int v; int due; } sig_t;
  typedef struct { int ch; logic [31:0] vs; logic [31:0] vn; int to; int due; } res_t;
  sig_t sig_q[$];
  int   start_q[$];
  res_t res_q[$];

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model of channel pointer, frame fill and per-channel history
  int m_ch = 0, m_cnt = 0, last_cyc = 0;
  bit m_run = 1'b0;
  logic signed [31:0] m_h0[NCH], m_h1[NCH];
  int m_fill[NCH];

  function automatic int bias(input int v);
    int r;
    r = v + 255;
    if (r < 0) r = 0;
    if (r > 510) r = 510;
    return r;
  endfunction

  function automatic logic signed [31:0] median(input logic signed [31:0] a, b, c);
    logic signed [31:0] t0, t1, t2, s;
    t0 = a; t1 = b; t2 = c;
    if (t0 > t1) begin s = t0; t0 = t1; t1 = s; end
    if (t1 > t2) begin s = t1; t1 = t2; t2 = s; end
    if (t0 > t1) begin s = t0; t0 = t1; t1 = s; end
    return t1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ch = 0; m_cnt = 0; m_run = 1'b0;
    for (int i = 0; i < NCH; i++) begin m_h0[i] = 0; m_h1[i] = 0; m_fill[i] = 0; end
  endtask

  task automatic send(input int ch, input int val);
    audio_ch = ch[0:0];
    audio    = val[SW:0];
    audio_v  = 1'b1;
    if (m_run && ch == m_ch) begin
      sig_q.push_back('{bias(val), cyc + 1});
      m_cnt++;
      if (m_cnt == WS) begin
        start_q.push_back(cyc + 1);
        m_cnt = 0; last_cyc = cyc; m_run = 1'b0;
      end
    end
    tick();
    audio_v = 1'b0;
  endtask

  task automatic send_n(input int n);
    int me, other;
    me = m_ch; other = (m_ch + 1) % NCH;
    for (int i = 0; i < n; i++) begin
      send(other, int'($urandom_range(0, 511)) - 256);
      send(me, int'($urandom_range(0, 511)) - 256);
    end
  endtask

  task automatic finish_frame();
    m_ch = (m_ch + 1) % NCH; m_cnt = 0; m_run = enable;
  endtask

  task automatic post_result(input int val);
    logic signed [31:0] nv, es;
    nv = val;
    es = (m_fill[m_ch] == 2) ? median(nv, m_h0[m_ch], m_h1[m_ch]) : nv;
    det_f = nv; det_fv = 1'b1;
    res_q.push_back('{m_ch, es, nv, 0, cyc + 1});
    m_h1[m_ch] = m_h0[m_ch]; m_h0[m_ch] = nv;
    if (m_fill[m_ch] < 2) m_fill[m_ch]++;
    tick();
    det_fv = 1'b0;
    tick();
    finish_frame();
  endtask

  task automatic give_result(input int val, input int wait_n);
    repeat (wait_n) tick();
    post_result(val);
  endtask

  always @(negedge clk) begin : mon
    sig_t se; res_t re; int sd;
    if (rst_n) begin
      if (det_sig_v) begin
        if (sig_q.size() == 0) chk("sig_spurious", 1, 0);
        else begin
          se = sig_q.pop_front();
          chk("det_sig", det_sig, se.v);
          chk("sig_latency", cyc, se.due);
        end
      end
      if (det_start) begin
        if (start_q.size() == 0) chk("start_spurious", 1, 0);
        else begin
          sd = start_q.pop_front();
          chk("start_cycle", cyc, sd);
        end
      end
      if (f_v || f_v_n) begin
        if (res_q.size() == 0) chk("res_spurious", 1, 0);
        else begin
          re = res_q.pop_front();
          chk("fv_smooth", f_v, 1);
          chk("fv_bypass", f_v_n, 1);
          chk("res_latency", cyc, re.due);
          chk("f_out_ch", f_ch, re.ch);
          chk("f_out_smooth", f_out, re.vs);
          chk("f_out_bypass", f_out_n, re.vn);
          chk("f_timeout", f_to, re.to);
          chk("f_timeout_bypass", f_to_n, re.to);
        end
      end
    end
  end

  int vals[6] = '{100, 300, 100, 120, 50, 110};

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_det_sig", det_sig, 0);
    chk("rst_sig_valid", det_sig_v, 0);
    chk("rst_start", det_start, 0);
    chk("rst_f_out", f_out, 0);
    chk("rst_f_valid", f_v, 0);
    chk("rst_timeout", f_to, 0);
    chk("rst_busy", busy, 0);

    rst_n = 1'b1; enable = 1'b1;
    tick(); m_run = 1'b1;
    // Bias boundaries on ch0 with ch1 traffic interleaved
    send(0, -256); send(1, 7); send(0, -1); send(1, -9); send(0, 0); send(0, 255);
    give_result(100, 3);
    for (int f = 0; f < 6; f++) begin
      send_n(WS);
      give_result(vals[f], 1 + f);
    end

    // Timeout frame, followed by a late result that must be ignored
    send_n(WS);
    res_q.push_back('{m_ch, 32'd0, 32'd0, 1, last_cyc + 17});
    while (cyc < last_cyc + 18) tick();
    det_f = 999; det_fv = 1'b1;
    tick();
    det_fv = 1'b0;
    finish_frame();

    // Stale result mid-stream
    send_n(2);
    det_f = 555; det_fv = 1'b1;
    tick();
    det_fv = 1'b0;
    send_n(2);
    give_result(500, 2);
    send_n(WS);
    give_result(200, 4);

    // Result on the timeout-expiry cycle wins
    send_n(WS);
    while (cyc < last_cyc + 16) tick();
    post_result(130);

    // Enable dropped mid-frame: frame drains, then idle
    send_n(2);
    enable = 1'b0;
    send_n(2);
    chk("busy_drain", busy, 1);
    give_result(40, 2);
    chk("busy_idle", busy, 0);
    chk("busy_idle_bypass", busy_n, 0);
    send(0, 100); send(1, -50);
    enable = 1'b1;
    tick(); m_run = 1'b1;

    // Async reset during WAIT
    send_n(WS);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_det_sig", det_sig, 0);
    chk("arst_f_out", f_out, 0);
    chk("arst_f_out_ch", f_ch, 0);
    chk("arst_f_valid", f_v, 0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick(); m_run = 1'b1;
    send_n(WS);
    give_result(77, 3);

    repeat (20) tick();
    chk("sig_q_empty", sig_q.size(), 0);
    chk("start_q_empty", start_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
